// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential unsigned shift-and-add multiplier.
// It borrows the combinational datapath ALU for every addition.
// The product is a[15:0] * b[N_BITS-1:0], exact in 32 bits.
// Optional build macro ALU_MUL_EARLY_EXIT_EN: once the remaining multiplier
// bits are all zero, the loop stops and the partial product is aligned in a
// single FIN step. This makes latency data-dependent; the product is unchanged.

package alu_mul_pkg;
  typedef enum logic [3:0] {
    F_A         = 4'h0,
    F_A_PLUS_B  = 4'h1,
    F_A_MINUS_B = 4'h2,
    F_B         = 4'h3
  } alu_op_t;
endpackage

module alu_mul_seq
  import alu_mul_pkg::*;
#(
  parameter int N_BITS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic        prod_hi_nz,
  output alu_op_t     alu_opcode,
  output logic [15:0] alu_inA,
  output logic [15:0] alu_inB,
  input  logic [15:0] alu_out,
  input  logic [3:0]  alu_cc
);

  localparam int CW = 5;

`ifdef ALU_MUL_EARLY_EXIT_EN
  typedef enum logic [2:0] {IDLE, ADD, SHIFT, FIN, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, ADD, SHIFT, DONE} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] r_q, r_d;
  logic [15:0] phi_q, phi_d;
  logic [15:0] plo_q, plo_d;
  logic        carry_q, carry_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] product_q, product_d;
  logic        hnz_q, hnz_d;

  // Only the carry flag takes part in the multiply.
  logic unused_cc;
  assign unused_cc = ^{alu_cc[3], alu_cc[1:0]};

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      r_q       <= '0;
      phi_q     <= '0;
      plo_q     <= '0;
      carry_q   <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
      hnz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      r_q       <= r_d;
      phi_q     <= phi_d;
      plo_q     <= plo_d;
      carry_q   <= carry_d;
      count_q   <= count_d;
      product_q <= product_d;
      hnz_q     <= hnz_d;
    end
  end

  // Next-state, datapath update and ALU drive.
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    r_d        = r_q;
    phi_d      = phi_q;
    plo_d      = plo_q;
    carry_d    = carry_q;
    count_d    = count_q;
    product_d  = product_q;
    hnz_d      = hnz_q;
    alu_opcode = F_A;
    alu_inA    = '0;
    alu_inB    = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          r_d     = 16'(b[N_BITS-1:0]);
          phi_d   = '0;
          plo_d   = '0;
          carry_d = 1'b0;
          count_d = CW'(N_BITS);
          state_d = ADD;
`ifdef ALU_MUL_EARLY_EXIT_EN
          // Decide the "nothing left to add" exit one state early, so the
          // exit itself costs no cycle.
          if (r_d == '0) state_d = FIN;
`endif
        end
      end
      ADD: begin
        alu_inA    = phi_q;
        alu_inB    = mcand_q;
        alu_opcode = r_q[0] ? F_A_PLUS_B : F_A;
        phi_d      = alu_out;
        carry_d    = r_q[0] & alu_cc[2];
        state_d    = SHIFT;
      end
      SHIFT: begin
        carry_d = 1'b0;
        phi_d   = {carry_q, phi_q[15:1]};
        plo_d   = {phi_q[0], plo_q[15:1]};
        r_d     = r_q >> 1;
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) begin
          // Load the product on the way into DONE, so it is valid while done is high.
          product_d = {carry_q, phi_q, plo_q[15:1]};
          hnz_d     = (product_d[31:16] != '0);
          state_d   = DONE;
        end else begin
          state_d = ADD;
`ifdef ALU_MUL_EARLY_EXIT_EN
          if (r_q[15:1] == '0) state_d = FIN;
`endif
        end
      end
`ifdef ALU_MUL_EARLY_EXIT_EN
      FIN: begin
        // Carry is already zero here, so the remaining shifts collapse into one.
        {phi_d, plo_d} = {phi_q, plo_q} >> count_q;
        product_d      = {phi_d, plo_d};
        hnz_d          = (product_d[31:16] != '0);
        state_d        = DONE;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign product    = product_q;
  assign prod_hi_nz = hnz_q;

endmodule
